instruction_fetch: RTL
======================

// Module: instruction_fetch
// PURPOSE
//  Instruction fetch/prefetch stage between the 10-bit program ROM (combinational
//  read, 16-bit words) and the F100-L execute core. Drives the ROM address, merges
//  an instruction word with its operand word when present, and buffers up to
//  DEPTH assembled instructions. Presents them to the core via valid/ready and
//  flushes on a core redirect (jump/call/return).
// PARAMETERS
//  ADDR_WIDTH  10  ROM word-address width; PC wraps modulo 2**ADDR_WIDTH
//  RESET_PC    0   fetch address loaded on reset
//  DEPTH       2   assembled-instruction queue entries (power of 2, >=2)
// PORTS
//  clk               in   1           system clock
//  reset             in   1           synchronous, active-high
//  rom_address       out  ADDR_WIDTH  ROM word address (drives rom.address)
//  rom_data_in       in   16          ROM word, valid in the same cycle as rom_address
//  insn_valid        out  1           queue head holds an instruction
//  insn_ready        in   1           core accepts head this cycle
//  insn_word         out  16          first instruction word
//  insn_operand      out  16          second word; 0 when insn_has_operand=0
//  insn_has_operand  out  1           instruction was two words
//  insn_pc           out  ADDR_WIDTH  address of insn_word
//  redirect_valid    in   1           core redirects fetch
//  redirect_pc       in   ADDR_WIDTH  new fetch address
//  halt              in   1           core halted; stop fetching
// BEHAVIOUR
//  - Reset: fetch_pc=RESET_PC, queue empty, state FETCH_FIRST, insn_valid=0,
//    insn_word/insn_operand/insn_has_operand/insn_pc=0, rom_address=RESET_PC.
//  - rom_address = fetch_pc, combinational from the register. ROM word is
//    sampled at the clock edge of the same cycle.
//  - Two-word rule: word[15:12]!=0 and word[10:0]==0. All other words, including
//    every F=0 word (e.g. 16'h0400 halt), are one word.
//  - FSM:
//    FETCH_FIRST: when the queue is not full and halt=0, capture the word and
//      fetch_pc+=1. A one-word instruction is pushed this edge. A two-word
//      instruction is held in a staging register (word, pc) and the FSM goes to
//      FETCH_OPERAND. Queue full: no capture, fetch_pc held.
//    FETCH_OPERAND: capture the operand, fetch_pc+=1, and push {word, operand, 1}
//      -> FETCH_FIRST. Queue full: wait. Halt does not abort an operand fetch.
//    HALTED: entered from FETCH_FIRST when halt=1. No captures. Leaves only on
//      redirect_valid or reset; the queue keeps draining.
//  - Latency from a capture edge: a one-word instruction is valid 1 cycle later.
//    A two-word instruction is valid 2 cycles after its first capture.
//    Sustained rate is 1 ROM word per cycle.
//  - Queue: a push and a pop in the same cycle are both allowed when full.
//    Pop occurs iff insn_valid && insn_ready. Outputs show the head and are
//    0 when empty.
//  - PC arithmetic wraps modulo 2**ADDR_WIDTH. Example: a two-word instruction
//    at 0x3FF takes its operand from 0x000.
//  - redirect_valid has priority over everything except reset. It empties the
//    queue and the staging register, sets fetch_pc=redirect_pc and goes to
//    FETCH_FIRST; nothing is captured that edge. A head popped in the same cycle
//    counts as consumed, and the first new instruction is valid 2 cycles after
//    redirect for one-word instructions.
//  - Reset mid-operand-fetch discards the staging register. No partial
//    instruction is ever presented.
// TESTING
//  1 ROM 8000,0014,4005,8000,0055,4b05,8014,0400, insn_ready=1 -> in order:
//    {8000,0014,1,pc0},{4005,-,0,pc2},{8000,0055,1,pc3},{4b05,pc5},{8014,pc6},
//    {0400,pc7}. First insn_valid 2 cycles after reset is released.
//  2 insn_ready=0 for 10 cycles -> queue holds exactly DEPTH entries and
//    rom_address stalls; releasing it drains with no loss or duplicates.
//  3 redirect_pc=5 while the queue is full and in FETCH_OPERAND -> queue flushed;
//    next valid is {4b05,pc5}. Same-cycle pop is counted once.
//  4 Two-word instruction at 0x3FF with operand word at 0x000 -> operand taken
//    from 0x000 and fetch_pc=1 afterwards.
//  5 halt=1 after 0400 is fetched -> no further rom_address advance; queue drains;
//    redirect to 0 resumes with {8000,0014}.
//  6 reset asserted in FETCH_OPERAND -> all outputs 0 next cycle and
//    rom_address=RESET_PC.

Source files
------------

// File: rtl/instruction_fetch.sv
// Fetch/prefetch stage: walks the program ROM, joins two-word instructions with
// their operand word and queues assembled instructions for the execute core.
module instruction_fetch #(
    parameter int ADDR_WIDTH = 10,
    parameter int RESET_PC   = 0,
    parameter int DEPTH      = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    output logic [ADDR_WIDTH-1:0] rom_address,
    input  logic [15:0]           rom_data_in,
    output logic                  insn_valid,
    input  logic                  insn_ready,
    output logic [15:0]           insn_word,
    output logic [15:0]           insn_operand,
    output logic                  insn_has_operand,
    output logic [ADDR_WIDTH-1:0] insn_pc,
    input  logic                  redirect_valid,
    input  logic [ADDR_WIDTH-1:0] redirect_pc,
    input  logic                  halt,
    output logic [1:0]            fetch_state
);

    typedef enum logic [1:0] {
        FETCH_FIRST   = 2'd0,
        FETCH_OPERAND = 2'd1,
        HALTED        = 2'd2
    } state_t;

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W:0] FULL_COUNT = (PTR_W + 1)'(DEPTH);

    state_t                state, state_next;
    logic [ADDR_WIDTH-1:0] fetch_pc;
    logic [15:0]           stage_word;
    logic [ADDR_WIDTH-1:0] stage_pc;

    logic [15:0]           q_word    [DEPTH];
    logic [15:0]           q_operand [DEPTH];
    logic                  q_has     [DEPTH];
    logic [ADDR_WIDTH-1:0] q_pc      [DEPTH];
    logic [PTR_W-1:0]      wr_ptr, rd_ptr;
    logic [PTR_W:0]        count;

    logic                  two_word, pop, can_push, push, stage_load, pc_advance;
    logic [15:0]           push_word, push_operand;
    logic                  push_has;
    logic [ADDR_WIDTH-1:0] push_pc;

    // Handshake: the head is consumed on any edge where insn_valid && insn_ready;
    // insn_valid never depends on insn_ready, and a full queue may push and pop together.
    assign two_word    = (rom_data_in[15:12] != 4'd0) && (rom_data_in[10:0] == 11'd0);
    assign pop         = insn_valid && insn_ready;
    assign can_push    = (count != FULL_COUNT) || pop;
    assign rom_address = fetch_pc;
    assign fetch_state = state;

    always_comb begin
        state_next   = state;
        push         = 1'b0;
        push_word    = rom_data_in;
        push_operand = 16'd0;
        push_has     = 1'b0;
        push_pc      = fetch_pc;
        stage_load   = 1'b0;
        pc_advance   = 1'b0;
        if (redirect_valid) begin
            state_next = FETCH_FIRST;
        end else begin
            case (state)
                FETCH_FIRST: begin
                    if (halt) begin
                        state_next = HALTED;
                    end else if (can_push) begin
                        pc_advance = 1'b1;
                        if (two_word) begin
                            stage_load = 1'b1;
                            state_next = FETCH_OPERAND;
                        end else begin
                            push = 1'b1;
                        end
                    end
                end
                FETCH_OPERAND: begin
                    // Halt is ignored here so a half-fetched instruction always completes.
                    if (can_push) begin
                        pc_advance   = 1'b1;
                        push         = 1'b1;
                        push_word    = stage_word;
                        push_operand = rom_data_in;
                        push_has     = 1'b1;
                        push_pc      = stage_pc;
                        state_next   = FETCH_FIRST;
                    end
                end
                HALTED:  state_next = HALTED;
                default: state_next = FETCH_FIRST;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= FETCH_FIRST;
            fetch_pc   <= ADDR_WIDTH'(RESET_PC);
            stage_word <= 16'd0;
            stage_pc   <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
        end else if (redirect_valid) begin
            state      <= FETCH_FIRST;
            fetch_pc   <= redirect_pc;
            stage_word <= 16'd0;
            stage_pc   <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
        end else begin
            state <= state_next;
            if (pc_advance) fetch_pc <= fetch_pc + ADDR_WIDTH'(1);
            if (stage_load) begin
                stage_word <= rom_data_in;
                stage_pc   <= fetch_pc;
            end
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + (PTR_W + 1)'(1);
                2'b01:   count <= count - (PTR_W + 1)'(1);
                default: count <= count;
            endcase
        end
    end

    // Entry storage needs no reset: outputs are masked whenever the queue is empty.
    always_ff @(posedge clk) begin
        if (push && !reset) begin
            q_word[wr_ptr]    <= push_word;
            q_operand[wr_ptr] <= push_operand;
            q_has[wr_ptr]     <= push_has;
            q_pc[wr_ptr]      <= push_pc;
        end
    end

    always_comb begin
        insn_valid       = (count != '0);
        insn_word        = 16'd0;
        insn_operand     = 16'd0;
        insn_has_operand = 1'b0;
        insn_pc          = '0;
        if (insn_valid) begin
            insn_word        = q_word[rd_ptr];
            insn_operand     = q_operand[rd_ptr];
            insn_has_operand = q_has[rd_ptr];
            insn_pc          = q_pc[rd_ptr];
        end
    end

endmodule
